exec_stage_pipe: RTL and testbench
==================================

Name: exec_stage_pipe

Overview:
- Parametrised, registered successor to the combinational execute stage.
- Selects operands (PC/rs1, imm/rs2), performs ALU op and branch compare, and delivers the result through an output register under valid/ready handshake.
- Sits between decode/regfile read and memory/writeback; carries a destination tag alongside the result.
- Optional iterative multiplier adds multi-cycle ops.

Parameters:
- XLEN, 32, datapath width; must be ≥8 and a power of 2.
- TAG_W, 5, width of the pass-through destination tag.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- flush  input  1  synchronous kill of in-flight op and output register.
- in_valid  input  1  operation present.
- in_ready  output  1  stage can accept.
- reg1, reg2  input  XLEN  rs1/rs2 values.
- pc_present  input  XLEN  PC of instruction.
- imm_o  input  XLEN  sign-extended immediate.
- alu_op  input  4  operation code (below).
- branch_control  input  3  compare code (below).
- alu_src_1, alu_src_2  input  1  operand selects.
- tag_in  input  TAG_W  destination tag.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts.
- result  output  XLEN  ALU result.
- branch_sel  output  1  branch taken.
- tag_out  output  TAG_W  tag of result.
- busy  output  1  multi-cycle op in progress.

Behaviour:
- Reset (async, rst=1): out_valid=0, result=0, branch_sel=0, tag_out=0, busy=0, FSM=IDLE. in_ready=0 while rst asserted.
- Operand selection:
  - opr1 = alu_src_1 ? reg1 : pc_present.
  - opr2 = alu_src_2 ? reg2 : imm_o.
- alu_op encoding:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT (signed), 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB (opr2).
  - 11 MUL (low XLEN), 12 MULHU (high XLEN, unsigned); both only with the optional feature.
  - 13–15 give 0.
  - Shifts use opr2[$clog2(XLEN)-1:0]. Add/sub wrap modulo 2^XLEN.
  - SLT/SLTU produce zero-extended 0/1.
- branch_control always compares reg1 vs reg2, never the muxed operands:
  - 000 EQ, 001 NE, 100 LT signed, 101 GE signed, 110 LTU, 111 GEU.
  - 011 always taken (jumps), 010 never taken.
- Handshake:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - in_ready = (state==IDLE) && (!out_valid || out_ready) && !rst. Accepting in the same cycle the output drains is allowed (full throughput, 1 op/cycle).
  - While out_valid && !out_ready, result/branch_sel/tag_out hold stable.
- FSM:
  - IDLE: accept. Single-cycle op → output regs loaded at that edge; out_valid=1 the next cycle (latency 1). MUL/MULHU accept → MUL, busy=1, count=0, operands/tag captured.
  - MUL: one shift-add step per cycle on 2·XLEN accumulator; after XLEN steps → IDLE. Result and tag are loaded, out_valid=1, busy=0. Latency from accept to out_valid = XLEN+1 cycles. in_ready=0 throughout.
  - The output register is guaranteed empty on MUL exit because in_ready required it at accept.
- flush=1 at an edge: out_valid→0, FSM→IDLE, busy→0, any input offered that cycle is dropped. flush has priority over accept and MUL completion. result/tag values after flush are don't-care but must not be reported valid.
- Reset mid-MUL: immediate return to IDLE with reset values; no result emitted.

Optional Feature:
- Macro EXEC_STAGE_MUL_EN.
- Defined: MUL FSM and ops 11/12 built as above.
- Undefined: ops 11/12 are single-cycle and return 0. The MUL state is absent, busy is tied 0, and in_ready never depends on FSM state.

Test Plan:
- XLEN=32, ADD, alu_src_1=1, alu_src_2=0, reg1=0x0000_0005, imm_o=0xFFFF_FFFF, tag_in=7, out_ready=1 → next cycle out_valid=1, result=0x0000_0004, tag_out=7.
- Back-to-back stream of 4 ops (SUB 3−5, SRA 0x8000_0000>>4, SLTU 1<0xFFFF_FFFF, PASSB imm 0x1234_5000) with out_ready=1 → 4 consecutive out_valid cycles with results 0xFFFF_FFFE, 0xF800_0000, 1, 0x1234_5000.
- branch_control=100, reg1=0xFFFF_FFFF, reg2=1 → branch_sel=1. Same operands with 110 → branch_sel=0.
- Backpressure: out_ready=0 for 3 cycles after first result → in_ready=0, result/tag stable. Raise out_ready → drains and accepts the next op in the same cycle.
- With EXEC_STAGE_MUL_EN: MUL 0xFFFF_FFFF×0xFFFF_FFFF → after 33 cycles result=0x0000_0001. MULHU with the same operands → 0xFFFF_FFFE. busy=1 for 32 cycles.
- flush asserted on cycle 10 of a MUL → busy=0 and in_ready=1 next cycle, no out_valid. Then rst pulse mid-op → all outputs 0 asynchronously.

Source files
------------

// File: rtl/exec_stage_pipe.sv
// Registered execute stage: operand mux, ALU, branch compare, valid/ready output register.
// Define EXEC_STAGE_MUL_EN to build the iterative MUL/MULHU unit.
module exec_stage_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  reg1,
  input  logic [XLEN-1:0]  reg2,
  input  logic [XLEN-1:0]  pc_present,
  input  logic [XLEN-1:0]  imm_o,
  input  logic [3:0]       alu_op,
  input  logic [2:0]       branch_control,
  input  logic             alu_src_1,
  input  logic             alu_src_2,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic             branch_sel,
  output logic [TAG_W-1:0] tag_out,
  output logic             busy
);

  localparam int SH_W = $clog2(XLEN);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_SLL   = 4'd2;
  localparam logic [3:0] OP_SLT   = 4'd3;
  localparam logic [3:0] OP_SLTU  = 4'd4;
  localparam logic [3:0] OP_XOR   = 4'd5;
  localparam logic [3:0] OP_SRL   = 4'd6;
  localparam logic [3:0] OP_SRA   = 4'd7;
  localparam logic [3:0] OP_OR    = 4'd8;
  localparam logic [3:0] OP_AND   = 4'd9;
  localparam logic [3:0] OP_PASSB = 4'd10;

  logic [XLEN-1:0]  opr1;
  logic [XLEN-1:0]  opr2;
  logic [SH_W-1:0]  shamt;
  logic [XLEN-1:0]  alu_res;
  logic             br_taken;
  logic             fire_in;
  logic             fire_out;
  logic             ld_alu;
  logic             ld_mul;
  logic [XLEN-1:0]  mul_res;
  logic [TAG_W-1:0] mul_tag;
  logic             mul_br;

  assign opr1     = alu_src_1 ? reg1 : pc_present;
  assign opr2     = alu_src_2 ? reg2 : imm_o;
  assign shamt    = opr2[SH_W-1:0];
  assign fire_in  = in_valid && in_ready;
  assign fire_out = out_valid && out_ready;

  always_comb begin
    alu_res = '0;
    case (alu_op)
      OP_ADD:   alu_res = opr1 + opr2;
      OP_SUB:   alu_res = opr1 - opr2;
      OP_SLL:   alu_res = opr1 << shamt;
      OP_SLT:   alu_res = {{(XLEN-1){1'b0}}, $signed(opr1) < $signed(opr2)};
      OP_SLTU:  alu_res = {{(XLEN-1){1'b0}}, opr1 < opr2};
      OP_XOR:   alu_res = opr1 ^ opr2;
      OP_SRL:   alu_res = opr1 >> shamt;
      OP_SRA:   alu_res = $unsigned($signed(opr1) >>> shamt);
      OP_OR:    alu_res = opr1 | opr2;
      OP_AND:   alu_res = opr1 & opr2;
      OP_PASSB: alu_res = opr2;
      default:  alu_res = '0;
    endcase
  end

  // Branches always compare the raw register values.
  always_comb begin
    br_taken = 1'b0;
    case (branch_control)
      3'b000:  br_taken = reg1 == reg2;
      3'b001:  br_taken = reg1 != reg2;
      3'b011:  br_taken = 1'b1;
      3'b100:  br_taken = $signed(reg1) < $signed(reg2);
      3'b101:  br_taken = $signed(reg1) >= $signed(reg2);
      3'b110:  br_taken = reg1 < reg2;
      3'b111:  br_taken = reg1 >= reg2;
      default: br_taken = 1'b0;
    endcase
  end

`ifdef EXEC_STAGE_MUL_EN
  typedef enum logic {S_IDLE, S_MUL} state_t;

  localparam logic [3:0] OP_MUL   = 4'd11;
  localparam logic [3:0] OP_MULHU = 4'd12;

  state_t            state;
  state_t            state_next;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] acc_step;
  logic [XLEN:0]     psum;
  logic [XLEN-1:0]   mcand;
  logic [SH_W-1:0]   count;
  logic              mul_hi;
  logic              is_mul;
  logic              last;

  assign is_mul   = (alu_op == OP_MUL) || (alu_op == OP_MULHU);
  assign last     = count == SH_W'(XLEN-1);
  // Low half holds the remaining multiplier bits; product shifts in from the top.
  assign psum     = {1'b0, acc[2*XLEN-1:XLEN]}
                  + {1'b0, (acc[0] ? mcand : {XLEN{1'b0}})};
  assign acc_step = {psum, acc[XLEN-1:1]};

  assign in_ready = (state == S_IDLE) && (!out_valid || out_ready) && !rst;
  assign busy     = state == S_MUL;
  assign ld_alu   = fire_in && !is_mul;
  assign ld_mul   = (state == S_MUL) && last;
  assign mul_res  = mul_hi ? acc_step[2*XLEN-1:XLEN] : acc_step[XLEN-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (fire_in && is_mul) state_next = S_MUL;
      S_MUL:   if (last) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (flush) state_next = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      mcand   <= '0;
      count   <= '0;
      mul_hi  <= 1'b0;
      mul_tag <= '0;
      mul_br  <= 1'b0;
    end else if (fire_in && is_mul) begin
      acc     <= {{XLEN{1'b0}}, opr2};
      mcand   <= opr1;
      count   <= '0;
      mul_hi  <= alu_op == OP_MULHU;
      mul_tag <= tag_in;
      mul_br  <= br_taken;
    end else if (state == S_MUL) begin
      acc     <= acc_step;
      count   <= count + 1'b1;
    end
  end
`else
  assign in_ready = (!out_valid || out_ready) && !rst;
  assign busy     = 1'b0;
  assign ld_alu   = fire_in;
  assign ld_mul   = 1'b0;
  assign mul_res  = '0;
  assign mul_tag  = '0;
  assign mul_br   = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      result     <= '0;
      branch_sel <= 1'b0;
      tag_out    <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
    end else if (ld_alu) begin
      out_valid  <= 1'b1;
      result     <= alu_res;
      branch_sel <= br_taken;
      tag_out    <= tag_in;
    end else if (ld_mul) begin
      out_valid  <= 1'b1;
      result     <= mul_res;
      branch_sel <= mul_br;
      tag_out    <= mul_tag;
    end else if (fire_out) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_exec_stage_pipe.sv
// Directed self-checking bench for exec_stage_pipe (XLEN=32, TAG_W=5).
// MUL scenarios are compiled in when EXEC_STAGE_MUL_EN is defined.
module tb_exec_stage_pipe;

  localparam int XLEN  = 32;
  localparam int TAG_W = 5;

  logic             clk;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  reg1;
  logic [XLEN-1:0]  reg2;
  logic [XLEN-1:0]  pc_present;
  logic [XLEN-1:0]  imm_o;
  logic [3:0]       alu_op;
  logic [2:0]       branch_control;
  logic             alu_src_1;
  logic             alu_src_2;
  logic [TAG_W-1:0] tag_in;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  result;
  logic             branch_sel;
  logic [TAG_W-1:0] tag_out;
  logic             busy;

  int checks;
  int errors;

  exec_stage_pipe #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .reg1(reg1), .reg2(reg2), .pc_present(pc_present), .imm_o(imm_o),
    .alu_op(alu_op), .branch_control(branch_control),
    .alu_src_1(alu_src_1), .alu_src_2(alu_src_2), .tag_in(tag_in),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .branch_sel(branch_sel), .tag_out(tag_out), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic s1, input logic s2,
                       input logic [31:0] r1, input logic [31:0] r2,
                       input logic [31:0] pcv, input logic [31:0] imm,
                       input logic [2:0] bc, input logic [4:0] tg);
    alu_op = op; alu_src_1 = s1; alu_src_2 = s2;
    reg1 = r1; reg2 = r2; pc_present = pcv; imm_o = imm;
    branch_control = bc; tag_in = tg;
  endtask

  task automatic test_reset;
    checks++;
    if (out_valid !== 1'b0 || result !== 32'h0 || tag_out !== 5'h0 ||
        branch_sel !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset: v=%b r=%h t=%h b=%b busy=%b ir=%b required all 0",
               out_valid, result, tag_out, branch_sel, busy, in_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b required 1", in_ready);
    end
  endtask

  task automatic test_add;
    drive(4'd0, 1'b1, 1'b0, 32'h5, 32'h0, 32'h0, 32'hFFFF_FFFF, 3'b010, 5'd7);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || result !== 32'h4 || tag_out !== 5'd7) begin
      errors++;
      $display("FAIL add: v=%b r=%h t=%0d required 1 00000004 7",
               out_valid, result, tag_out);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL add_drain: out_valid %b required 0", out_valid);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp [4];
    exp = '{32'hFFFF_FFFE, 32'hF800_0000, 32'h1, 32'h1234_5000};
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: drive(4'd1, 1'b1, 1'b1, 32'd3, 32'd5, 32'h0, 32'h0, 3'b010, 5'd1);
        1: drive(4'd7, 1'b1, 1'b0, 32'h8000_0000, 32'h0, 32'h0, 32'd4, 3'b010, 5'd2);
        2: drive(4'd4, 1'b1, 1'b1, 32'h1, 32'hFFFF_FFFF, 32'h0, 32'h0, 3'b010, 5'd3);
        default: drive(4'd10, 1'b1, 1'b0, 32'h0, 32'h9, 32'h0, 32'h1234_5000, 3'b010, 5'd4);
      endcase
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready[%0d]: got %b required 1", i, in_ready);
      end
      step();
      checks++;
      if (out_valid !== 1'b1 || result !== exp[i] || tag_out !== 5'(i + 1)) begin
        errors++;
        $display("FAIL b2b[%0d]: v=%b r=%h t=%0d required 1 %h %0d",
                 i, out_valid, result, tag_out, exp[i], i + 1);
      end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_alu_ops;
    logic [3:0]  ops [9];
    logic [31:0] pcs [9];
    logic [31:0] imms [9];
    logic [31:0] exp [9];
    ops  = '{4'd2, 4'd6, 4'd5, 4'd8, 4'd9, 4'd3, 4'd0, 4'd13, 4'd15};
    pcs  = '{32'h1, 32'h8000_0000, 32'hF0F0_F0F0, 32'h0F00_0000,
             32'hFFFF_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h5, 32'h5};
    imms = '{32'h21, 32'd31, 32'hFF00_FF00, 32'h0000_00F0,
             32'h1234_5678, 32'h1, 32'h1, 32'h6, 32'h6};
    exp  = '{32'h2, 32'h1, 32'h0FF0_0FF0, 32'h0F00_00F0,
             32'h1234_0000, 32'h1, 32'h0, 32'h0, 32'h0};
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 9; i++) begin
      drive(ops[i], 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0000_0003, pcs[i], imms[i], 3'b010, 5'd9);
      step();
      checks++;
      if (out_valid !== 1'b1 || result !== exp[i]) begin
        errors++;
        $display("FAIL alu_op%0d: v=%b r=%h required 1 %h", ops[i], out_valid, result, exp[i]);
      end
    end
`ifndef EXEC_STAGE_MUL_EN
    drive(4'd11, 1'b1, 1'b1, 32'd3, 32'd5, 32'h0, 32'h0, 3'b010, 5'd10);
    step();
    checks++;
    if (out_valid !== 1'b1 || result !== 32'h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mul_disabled: v=%b r=%h busy=%b required 1 00000000 0",
               out_valid, result, busy);
    end
`endif
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_branch;
    logic [2:0]  bcs [8];
    logic [31:0] r1s [8];
    logic [31:0] r2s [8];
    logic        exp [8];
    bcs = '{3'b100, 3'b110, 3'b000, 3'b001, 3'b101, 3'b111, 3'b011, 3'b010};
    r1s = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h5, 32'h5,
            32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 32'h1};
    r2s = '{32'h1, 32'h1, 32'h5, 32'h5, 32'h1, 32'h1, 32'h2, 32'h1};
    exp = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      // Muxed operands deliberately disagree with reg1/reg2.
      drive(4'd0, 1'b0, 1'b0, r1s[i], r2s[i], 32'h7, 32'h7, bcs[i], 5'd11);
      step();
      checks++;
      if (out_valid !== 1'b1 || branch_sel !== exp[i]) begin
        errors++;
        $display("FAIL branch_%b: v=%b taken=%b required 1 %b",
                 bcs[i], out_valid, branch_sel, exp[i]);
      end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_backpressure;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    drive(4'd0, 1'b1, 1'b0, 32'd10, 32'h0, 32'h0, 32'd1, 3'b010, 5'd3);
    step();
    drive(4'd0, 1'b1, 1'b0, 32'd20, 32'h0, 32'h0, 32'd2, 3'b010, 5'd4);
    out_ready = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_ready: got %b required 0", in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || result !== 32'd11 || tag_out !== 5'd3 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: v=%b r=%h t=%0d ir=%b required 1 0000000b 3 0",
                 i, out_valid, result, tag_out, in_ready);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release_ready: got %b required 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || result !== 32'd22 || tag_out !== 5'd4) begin
      errors++;
      $display("FAIL bp_next: v=%b r=%h t=%0d required 1 00000016 4",
               out_valid, result, tag_out);
    end
    step();
  endtask

  task automatic test_flush;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    flush     = 1'b1;
    drive(4'd0, 1'b1, 1'b1, 32'd1, 32'd1, 32'h0, 32'h0, 3'b010, 5'd5);
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_drop: out_valid %b required 0", out_valid);
    end
    flush = 1'b0;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_kill: out_valid %b required 0", out_valid);
    end
    out_ready = 1'b1;
  endtask

`ifdef EXEC_STAGE_MUL_EN
  task automatic test_mul;
    logic [3:0]  ops [2];
    logic [31:0] exp [2];
    int n;
    ops = '{4'd11, 4'd12};
    exp = '{32'h0000_0001, 32'hFFFF_FFFE};
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(ops[i], 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 3'b010, 5'(12 + i));
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      n = 0;
      while (busy === 1'b1 && n < 100) begin
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
          errors++;
          $display("FAIL mul_busy_ready[%0d]: ir=%b v=%b required 0 0", n, in_ready, out_valid);
        end
        n++;
        step();
      end
      checks++;
      if (n !== 32 || out_valid !== 1'b1 || result !== exp[i] || tag_out !== 5'(12 + i)) begin
        errors++;
        $display("FAIL mul_op%0d: busy=%0d v=%b r=%h t=%0d required 32 1 %h %0d",
                 ops[i], n, out_valid, result, tag_out, exp[i], 12 + i);
      end
      step();
    end
  endtask

  task automatic test_mul_abort;
    int seen;
    drive(4'd11, 1'b1, 1'b1, 32'd7, 32'd9, 32'h0, 32'h0, 3'b010, 5'd20);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mul_flush: busy=%b ir=%b v=%b required 0 1 0", busy, in_ready, out_valid);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL mul_flush_no_result: out_valid cycles %0d required 0", seen);
    end
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || result !== 32'h0 ||
        tag_out !== 5'h0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL mul_reset: busy=%b v=%b r=%h t=%h ir=%b required 0 0 0 0 0",
               busy, out_valid, result, tag_out, in_ready);
    end
    step();
    rst = 1'b0;
    for (int i = 0; i < 40; i++) step();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mul_reset_no_result: v=%b busy=%b required 0 0", out_valid, busy);
    end
  endtask
`endif

  task automatic test_async_reset;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    drive(4'd10, 1'b1, 1'b1, 32'h0, 32'hABCD_0123, 32'h0, 32'h0, 3'b011, 5'd30);
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || result !== 32'h0 || tag_out !== 5'h0 ||
        branch_sel !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: v=%b r=%h t=%h b=%b ir=%b required 0 0 0 0 0",
               out_valid, result, tag_out, branch_sel, in_ready);
    end
    step();
    rst = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    drive(4'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 3'b010, 5'd0);
    step();
    step();
    test_reset();
    test_add();
    test_back_to_back();
    test_alu_ops();
    test_branch();
    test_backpressure();
    test_flush();
`ifdef EXEC_STAGE_MUL_EN
    test_mul();
    test_mul_abort();
`endif
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
